rr_mux8_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the 8:1 16-bit mux datapath. Eight

---
 rtl/rr_mux8_arbiter.sv | 112 +++++++++++
 tb/tb_rr_mux8_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter for eight requesters feeding an 8:1 mux; the selected word
// is registered and handed downstream on a valid/ready handshake with no bubbles.
module rr_mux8_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    input  logic [WIDTH-1:0] din4,
    input  logic [WIDTH-1:0] din5,
    input  logic [WIDTH-1:0] din6,
    input  logic [WIDTH-1:0] din7,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    output logic [2:0]       sel,
    output logic [7:0]       gnt,
    output logic [7:0]       ack,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q;
    logic [2:0]       ptr_q;
    logic [2:0]       sel_q;
    logic [7:0]       gnt_q;
    logic [WIDTH-1:0] dout_q;
    logic [CNT_W-1:0] cnt_q;

    logic             hs;
    logic [2:0]       arb_base;
    logic [2:0]       idx;
    logic [2:0]       win_d;
    logic             found_d;
    logic [WIDTH-1:0] words [8];

    // On a handshake the arbitration base is the freshly advanced pointer,
    // so the requester just served gets the lowest priority.
    always_comb begin
        words[0] = din0;
        words[1] = din1;
        words[2] = din2;
        words[3] = din3;
        words[4] = din4;
        words[5] = din5;
        words[6] = din6;
        words[7] = din7;
        hs       = (state_q == SEND) && out_ready;
        arb_base = hs ? sel_q + 3'd1 : ptr_q;
        idx      = '0;
        win_d    = '0;
        found_d  = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = arb_base + 3'(i);
            if (!found_d && req[idx]) begin
                found_d = 1'b1;
                win_d   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= SEND;
                        sel_q   <= win_d;
                        gnt_q   <= 8'b1 << win_d;
                        dout_q  <= words[win_d];
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        ptr_q <= sel_q + 3'd1;
                        if (found_d) begin
                            sel_q  <= win_d;
                            gnt_q  <= 8'b1 << win_d;
                            dout_q <= words[win_d];
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == SEND);
    assign dout      = dout_q;
    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign ack       = gnt_q & {8{out_valid & out_ready}};
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Self-checking bench for rr_mux8_arbiter: vector table, directed corner cases,
// and a randomized run against a behavioural round-robin model.
module tb_rr_mux8_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic        out_ready;
    logic [15:0] din_a [8];
    logic        out_valid;
    logic [15:0] dout;
    logic [2:0]  sel;
    logic [7:0]  gnt;
    logic [7:0]  ack;
    logic [15:0] xfer_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_mux8_arbiter #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req(req),
        .din0(din_a[0]), .din1(din_a[1]), .din2(din_a[2]), .din3(din_a[3]),
        .din4(din_a[4]), .din5(din_a[5]), .din6(din_a[6]), .din7(din_a[7]),
        .out_ready(out_ready), .out_valid(out_valid), .dout(dout), .sel(sel),
        .gnt(gnt), .ack(ack), .xfer_cnt(xfer_cnt)
    );

    typedef struct packed {
        logic        rst;
        logic [7:0]  req;
        logic        rdy;
        logic        v;
        logic [2:0]  sel;
        logic [15:0] dout;
        logic [7:0]  gnt;
        logic [7:0]  ack;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic [7:0] q, input logic rd);
        rst = r; req = q; out_ready = rd;
        #1;
    endtask

    task automatic set_default_din();
        for (int k = 0; k < 8; k++) din_a[k] = 16'(k + 1);
    endtask

    // Behavioural model: first requester at or after ptr, modulo 8.
    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    int          m_ptr, m_sel, m_w;
    logic        m_valid;
    logic [15:0] m_dout, m_cnt;

    initial begin
        rst = 1'b1; req = '0; out_ready = 1'b0;
        set_default_din();

        // Reset held for two cycles
        @(negedge clk);
        cyc();
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_dout", dout, 0);
        chk("rst_sel", sel, 0);
        chk("rst_cnt", xfer_cnt, 0);
        chk("rst_ack", ack, 0);

        // Rows: inputs this cycle, outputs observed this cycle before the edge.
        tbl.push_back('{1'b0, 8'h08, 1'b1, 1'b0, 3'd0, 16'd0, 8'h00, 8'h00, 16'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 16'd4, 8'h08, 8'h08, 16'd0});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 16'd4, 8'h00, 8'h00, 16'd1});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 3'd3, 16'd4, 8'h00, 8'h00, 16'd1});
        tbl.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 16'd0, 8'h00, 8'h00, 16'd0});
        for (int i = 0; i < 9; i++)
            tbl.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 3'(i % 8), 16'((i % 8) + 1),
                            8'(1 << (i % 8)), 8'(1 << (i % 8)), 16'(i)});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 16'd2, 8'h02, 8'h00, 16'd9});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 3'd1, 16'd2, 8'h02, 8'h02, 16'd9});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 16'd2, 8'h00, 8'h00, 16'd10});

        foreach (tbl[n]) begin
            drive(tbl[n].rst, tbl[n].req, tbl[n].rdy);
            chk($sformatf("tbl%0d_valid", n), out_valid, tbl[n].v);
            chk($sformatf("tbl%0d_sel", n), sel, tbl[n].sel);
            if (tbl[n].v) chk($sformatf("tbl%0d_dout", n), dout, tbl[n].dout);
            chk($sformatf("tbl%0d_gnt", n), gnt, tbl[n].gnt);
            chk($sformatf("tbl%0d_ack", n), ack, tbl[n].ack);
            chk($sformatf("tbl%0d_cnt", n), xfer_cnt, tbl[n].cnt);
            cyc();
        end

        // Stall: word held for five cycles with no ack (ptr=2, cnt=10 here)
        din_a[4] = 16'd10;
        drive(1'b0, 8'h10, 1'b0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h10, 1'b0);
            chk("stall_valid", out_valid, 1);
            chk("stall_dout", dout, 10);
            chk("stall_sel", sel, 4);
            chk("stall_ack", ack, 0);
            cyc();
        end
        drive(1'b0, 8'h00, 1'b1);
        chk("stall_ack_rdy", ack, 8'h10);
        cyc();
        set_default_din();

        // Rotation: 5, then req 44 joins on the handshake -> 6, then 2
        drive(1'b0, 8'h20, 1'b1);
        cyc();
        drive(1'b0, 8'h44, 1'b1);
        chk("rot_sel5", sel, 5);
        chk("rot_ack5", ack, 8'h20);
        cyc();
        drive(1'b0, 8'h44, 1'b1);
        chk("rot_sel6", sel, 6);
        chk("rot_gnt6", gnt, 8'h40);
        chk("rot_dout6", dout, 7);
        cyc();
        drive(1'b0, 8'h00, 1'b1);
        chk("rot_sel2", sel, 2);
        chk("rot_gnt2", gnt, 8'h04);
        cyc();
        // Wrap 7 -> 0
        drive(1'b0, 8'h80, 1'b1);
        chk("wrap_idle", out_valid, 0);
        cyc();
        drive(1'b0, 8'h81, 1'b1);
        chk("wrap_sel7", sel, 7);
        cyc();
        drive(1'b0, 8'h00, 1'b1);
        chk("wrap_sel0", sel, 0);
        chk("wrap_dout0", dout, 1);
        cyc();
        drive(1'b0, 8'h00, 1'b0);
        chk("wrap_cnt", xfer_cnt, 16);

        // Reset mid-SEND while stalled
        drive(1'b0, 8'h08, 1'b0);
        cyc();
        drive(1'b1, 8'h08, 1'b0);
        chk("mrst_pre_valid", out_valid, 1);
        chk("mrst_ack", ack, 0);
        cyc();
        drive(1'b0, 8'h81, 1'b0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_gnt", gnt, 0);
        chk("mrst_cnt", xfer_cnt, 0);
        cyc();
        drive(1'b0, 8'h00, 1'b1);
        chk("mrst_sel0", sel, 0);
        chk("mrst_gnt0", gnt, 8'h01);
        chk("mrst_dout0", dout, 1);
        cyc();

        // Randomized run against the model, starting from a clean reset
        drive(1'b1, 8'h00, 1'b0);
        cyc();
        m_valid = 0; m_sel = 0; m_ptr = 0; m_dout = 0; m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 8; k++) din_a[k] = 16'($urandom);
            drive(($urandom_range(0, 63) == 0), 8'($urandom & $urandom), ($urandom_range(0, 3) != 0));
            chk("rnd_valid", out_valid, m_valid);
            chk("rnd_sel", sel, m_sel);
            chk("rnd_gnt", gnt, m_valid ? 32'(1 << m_sel) : 0);
            chk("rnd_ack", ack, (m_valid && out_ready) ? 32'(1 << m_sel) : 0);
            chk("rnd_cnt", xfer_cnt, m_cnt);
            if (m_valid) chk("rnd_dout", dout, m_dout);
            if (rst) begin
                m_valid = 0; m_sel = 0; m_ptr = 0; m_dout = 0; m_cnt = 0;
            end else if (!m_valid || out_ready) begin
                if (m_valid) begin
                    m_cnt++;
                    m_ptr = (m_sel + 1) % 8;
                end
                m_w = pick(req, m_ptr);
                if (m_w >= 0) begin
                    m_valid = 1; m_sel = m_w; m_dout = din_a[m_w];
                end else begin
                    m_valid = 0;
                end
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
